// File: rtl/lcg_sequencer.sv
// lcg_sequencer: iterative 16x16 shift-add LCG unit (x <= a*x + c), stalls the pipe and writes back 16/32-bit results
module lcg_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul_en,
    input  logic        MUL,
    input  logic        loop,
    input  logic        MSB,
    input  logic [15:0] rd_val,
    input  logic [15:0] rs_val,
    input  logic [15:0] gp5,
    input  logic [15:0] loop_cnt,
    input  logic [2:0]  rd_idx,
    output logic        stall,
    output logic        busy,
    output logic        wr_en,
    output logic [2:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, MULT, ACC, WB_LO, WB_HI} state_t;
    state_t      state;
    logic [31:0] p;
    logic [31:0] p_acc;
    logic [15:0] mcand;
    logic [15:0] mplr;
    logic [15:0] a;
    logic [15:0] c;
    logic [15:0] iters;
    logic [3:0]  bit_cnt;
    logic [16:0] sum;
    logic        msb;
    logic [2:0]  rd;

    assign sum   = mplr[0] ? {1'b0, p[31:16]} + {1'b0, mcand} : {1'b0, p[31:16]};
    assign p_acc = p + {16'b0, c};
    assign busy  = state != IDLE;
    assign stall = (state == IDLE && mul_en) || (busy && !done);

    // sequencer: issue latch, 16 shift-add steps, accumulate/loop, then one or two write-backs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            p       <= '0;
            mcand   <= '0;
            mplr    <= '0;
            a       <= '0;
            c       <= '0;
            iters   <= '0;
            bit_cnt <= '0;
            msb     <= 1'b0;
            rd      <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (mul_en) begin
                    mcand   <= rd_val;
                    mplr    <= rs_val;
                    a       <= rs_val;
                    c       <= MUL ? 16'd0 : gp5;
                    iters   <= (loop && loop_cnt != 16'd0) ? loop_cnt : 16'd1;
                    msb     <= MSB;
                    rd      <= rd_idx;
                    p       <= '0;
                    bit_cnt <= '0;
                    state   <= MULT;
                end
                MULT: begin
                    p       <= {sum, p[15:1]};
                    mplr    <= mplr >> 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) state <= ACC;
                end
                ACC: if (iters > 16'd1) begin
                    iters <= iters - 16'd1;
                    mcand <= p_acc[15:0];
                    mplr  <= a;
                    p     <= '0;
                    state <= MULT;
                end else begin
                    p       <= p_acc;
                    wr_en   <= 1'b1;
                    wr_addr <= rd;
                    wr_data <= p_acc[15:0];
                    done    <= !msb;
                    state   <= WB_LO;
                end
                WB_LO: if (msb) begin
                    wr_en   <= 1'b1;
                    wr_addr <= 3'd5;
                    wr_data <= p[31:16];
                    done    <= 1'b1;
                    state   <= WB_HI;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
